// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard.
// Holds a pending-write counter per architectural register and decides which of
// two in-order decoded instructions may issue this cycle. A register that is
// being retired on a writeback port this cycle counts as available, because the
// register file bypasses same-cycle write data to reads.
module issue_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pipe_ready,
    input  logic        valid_1,
    input  logic        re1_1,
    input  logic [4:0]  raddr1_1,
    input  logic        re2_1,
    input  logic [4:0]  raddr2_1,
    input  logic        we_1,
    input  logic [4:0]  waddr_1,
    input  logic        valid_2,
    input  logic        re1_2,
    input  logic [4:0]  raddr1_2,
    input  logic        re2_2,
    input  logic [4:0]  raddr2_2,
    input  logic        we_2,
    input  logic [4:0]  waddr_2,
    input  logic        wb_we_1,
    input  logic [4:0]  wb_waddr_1,
    input  logic        wb_we_2,
    input  logic [4:0]  wb_waddr_2,
    output logic        issue_1,
    output logic        issue_2,
    output logic [31:0] stall_cnt,
    output logic [31:0] busy_vec
);

    // Sum width: holds pending + two issues without overflow.
    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pending  [32];
    logic [CNT_W-1:0] pend_nxt [32];
    logic [1:0]       wb_cnt   [32];
    logic [SW-1:0]    inc_r    [32];
    logic [SW-1:0]    sum_r    [32];
    logic [31:0]      avail;

    logic wr_ok_1, wr_ok_2;
    logic ok_1, ok_2;
    logic raw_12, waw_full;

    // Per-register writeback hit count and read availability.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            wb_cnt[r] = 2'(wb_we_1 && (wb_waddr_1 == 5'(r)))
                      + 2'(wb_we_2 && (wb_waddr_2 == 5'(r)));
            // Retiring at least as many writes as are pending frees the register.
            avail[r]  = (r == 0) || (SW'(pending[r]) <= SW'(wb_cnt[r]));
        end
    end

    // Per-slot hazard checks and the in-order issue decision.
    always_comb begin
        wr_ok_1  = !we_1 || (waddr_1 == 5'd0) || (pending[waddr_1] != CNT_MAX);
        wr_ok_2  = !we_2 || (waddr_2 == 5'd0) || (pending[waddr_2] != CNT_MAX);
        ok_1     = (!re1_1 || avail[raddr1_1]) && (!re2_1 || avail[raddr2_1]) && wr_ok_1;
        ok_2     = (!re1_2 || avail[raddr1_2]) && (!re2_2 || avail[raddr2_2]) && wr_ok_2;
        // Slot 2 must not read what the older slot 1 is about to write.
        raw_12   = we_1 && (waddr_1 != 5'd0)
                && ((re1_2 && (raddr1_2 == waddr_1)) || (re2_2 && (raddr2_2 == waddr_1)));
        // Two writes to one register need room for both increments.
        waw_full = we_1 && we_2 && (waddr_1 == waddr_2) && (waddr_1 != 5'd0)
                && ((SW'(pending[waddr_1]) + SW'(2)) > SW'(CNT_MAX));
        issue_1  = !rst && !flush && pipe_ready && valid_1 && ok_1;
        issue_2  = issue_1 && valid_2 && ok_2 && !raw_12 && !waw_full;
    end

    // Next pending count: add issued writes, subtract retirements, clamp at zero.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            inc_r[r] = SW'(issue_1 && we_1 && (waddr_1 == 5'(r)))
                     + SW'(issue_2 && we_2 && (waddr_2 == 5'(r)));
            sum_r[r] = SW'(pending[r]) + inc_r[r];
            if (r == 0) begin
                pend_nxt[r] = '0;
            end else if (sum_r[r] <= SW'(wb_cnt[r])) begin
                pend_nxt[r] = '0;
            end else begin
                pend_nxt[r] = CNT_W'(sum_r[r] - SW'(wb_cnt[r]));
            end
        end
    end

    // Scoreboard and stall counter state; reset outranks flush, flush outranks updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) pending[r] <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) pending[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) pending[r] <= pend_nxt[r];
            if (valid_1 && !issue_1) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Busy view of the registered counters.
    always_comb begin
        for (int r = 0; r < 32; r++) busy_vec[r] = (pending[r] != '0);
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: directed scenarios followed by random traffic,
// each cycle checked against a counter-per-register reference model.
module tb_issue_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, pipe_ready;
    logic        valid_1, re1_1, re2_1, we_1;
    logic [4:0]  raddr1_1, raddr2_1, waddr_1;
    logic        valid_2, re1_2, re2_2, we_2;
    logic [4:0]  raddr1_2, raddr2_2, waddr_2;
    logic        wb_we_1, wb_we_2;
    logic [4:0]  wb_waddr_1, wb_waddr_2;
    logic        issue_1, issue_2;
    logic [31:0] stall_cnt, busy_vec;

    issue_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pipe_ready(pipe_ready),
        .valid_1(valid_1), .re1_1(re1_1), .raddr1_1(raddr1_1), .re2_1(re2_1),
        .raddr2_1(raddr2_1), .we_1(we_1), .waddr_1(waddr_1),
        .valid_2(valid_2), .re1_2(re1_2), .raddr1_2(raddr1_2), .re2_2(re2_2),
        .raddr2_2(raddr2_2), .we_2(we_2), .waddr_2(waddr_2),
        .wb_we_1(wb_we_1), .wb_waddr_1(wb_waddr_1),
        .wb_we_2(wb_we_2), .wb_waddr_2(wb_waddr_2),
        .issue_1(issue_1), .issue_2(issue_2),
        .stall_cnt(stall_cnt), .busy_vec(busy_vec)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pend [32];
    logic [31:0] stall_m;
    logic        obs_i1, obs_i2;
    logic [31:0] obs_busy, obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: how many writeback ports retire register r this cycle.
    function automatic int wbn(input logic [4:0] r);
        int n = 0;
        if (wb_we_1 && wb_waddr_1 == r) n++;
        if (wb_we_2 && wb_waddr_2 == r) n++;
        return n;
    endfunction

    function automatic bit avail(input logic [4:0] r);
        return (r == 0) || (pend[r] - wbn(r) <= 0);
    endfunction

    function automatic bit slot_ok(input logic e1, input logic [4:0] a1, input logic e2,
                                   input logic [4:0] a2, input logic w, input logic [4:0] wa);
        return (!e1 || avail(a1)) && (!e2 || avail(a2)) && (!w || wa == 0 || pend[wa] < MAXP);
    endfunction

    // One clock: check outputs at negedge against the model, advance the model, cross posedge.
    task automatic cycle(input string tag);
        bit          e1, e2;
        logic [31:0] bexp;
        int          p;
        @(negedge clk);
        e1 = !rst && !flush && pipe_ready && valid_1
             && slot_ok(re1_1, raddr1_1, re2_1, raddr2_1, we_1, waddr_1);
        e2 = e1 && valid_2 && slot_ok(re1_2, raddr1_2, re2_2, raddr2_2, we_2, waddr_2)
             && !(we_1 && waddr_1 != 0 && ((re1_2 && raddr1_2 == waddr_1) || (re2_2 && raddr2_2 == waddr_1)))
             && !(we_1 && we_2 && waddr_1 == waddr_2 && waddr_1 != 0 && pend[waddr_1] > MAXP - 2);
        for (int r = 0; r < 32; r++) bexp[r] = (pend[r] != 0);
        obs_i1 = issue_1; obs_i2 = issue_2; obs_busy = busy_vec; obs_stall = stall_cnt;
        chk({tag, ".issue_1"}, 32'(issue_1), 32'(e1));
        chk({tag, ".issue_2"}, 32'(issue_2), 32'(e2));
        chk({tag, ".busy_vec"}, busy_vec, bexp);
        chk({tag, ".stall_cnt"}, stall_cnt, stall_m);
        if (rst) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
            stall_m = 0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
        end else begin
            if (valid_1 && !e1) stall_m = stall_m + 1;
            for (int r = 1; r < 32; r++) begin
                p = pend[r];
                if (e1 && we_1 && waddr_1 == r) p++;
                if (e2 && we_2 && waddr_2 == r) p++;
                p = p - wbn(5'(r));
                if (p < 0) p = 0;
                pend[r] = p;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rst = 0; flush = 0; pipe_ready = 1;
        valid_1 = 0; re1_1 = 0; raddr1_1 = 0; re2_1 = 0; raddr2_1 = 0; we_1 = 0; waddr_1 = 0;
        valid_2 = 0; re1_2 = 0; raddr1_2 = 0; re2_2 = 0; raddr2_2 = 0; we_2 = 0; waddr_2 = 0;
        wb_we_1 = 0; wb_waddr_1 = 0; wb_we_2 = 0; wb_waddr_2 = 0;
    endtask

    task automatic set_s1(input logic e1, input logic [4:0] a1, input logic e2,
                          input logic [4:0] a2, input logic w, input logic [4:0] wa);
        valid_1 = 1; re1_1 = e1; raddr1_1 = a1; re2_1 = e2; raddr2_1 = a2; we_1 = w; waddr_1 = wa;
    endtask

    task automatic set_s2(input logic e1, input logic [4:0] a1, input logic e2,
                          input logic [4:0] a2, input logic w, input logic [4:0] wa);
        valid_2 = 1; re1_2 = e1; raddr1_2 = a1; re2_2 = e2; raddr2_2 = a2; we_2 = w; waddr_2 = wa;
    endtask

    task automatic set_wb(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        wb_we_1 = e1; wb_waddr_1 = a1; wb_we_2 = e2; wb_waddr_2 = a2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) pend[r] = 0;
        stall_m = 0;
        clear();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;

        // Reset held with a valid instruction offered: nothing issues.
        set_s1(0, 0, 0, 0, 1, 5'd5);
        cycle("rst_hold");
        chk("rst_hold.i1", 32'(obs_i1), 32'd0);
        chk("rst_hold.busy", obs_busy, 32'd0);
        chk("rst_hold.stall", obs_stall, 32'd0);

        // Write r5, then a dependent read stalls until r5 retires (bypass).
        clear(); set_s1(0, 0, 0, 0, 1, 5'd5);
        cycle("w5");
        chk("w5.i1", 32'(obs_i1), 32'd1);
        clear(); set_s1(1, 5'd5, 0, 0, 0, 0);
        cycle("raw5_stall");
        chk("raw5_stall.i1", 32'(obs_i1), 32'd0);
        set_wb(1, 5'd5, 0, 0);
        cycle("raw5_bypass");
        chk("raw5_bypass.i1", 32'(obs_i1), 32'd1);
        chk("raw5_bypass.stall", obs_stall, 32'd1);
        clear();
        cycle("after5");
        chk("after5.busy5", 32'(obs_busy[5]), 32'd0);

        // Intra-group RAW: slot 2 reads r3 written by slot 1.
        set_s1(0, 0, 0, 0, 1, 5'd3); set_s2(1, 5'd3, 0, 0, 0, 0);
        cycle("raw3");
        chk("raw3.i1", 32'(obs_i1), 32'd1);
        chk("raw3.i2", 32'(obs_i2), 32'd0);
        clear();
        cycle("after3");
        chk("after3.busy3", 32'(obs_busy[3]), 32'd1);
        set_wb(1, 5'd3, 0, 0);
        cycle("ret3");

        // Double write to r7 near the counter limit.
        clear(); set_s1(0, 0, 0, 0, 1, 5'd7);
        cycle("w7a");
        cycle("w7b");
        set_s2(0, 0, 0, 0, 1, 5'd7);
        cycle("waw7");
        chk("waw7.i1", 32'(obs_i1), 32'd1);
        chk("waw7.i2", 32'(obs_i2), 32'd0);
        clear(); set_s1(0, 0, 0, 0, 1, 5'd7);
        cycle("full7");
        chk("full7.i1", 32'(obs_i1), 32'd0);
        set_wb(1, 5'd7, 0, 0);
        cycle("full7_wb");
        chk("full7_wb.i1", 32'(obs_i1), 32'd0);
        set_wb(0, 0, 0, 0);
        cycle("room7");
        chk("room7.i1", 32'(obs_i1), 32'd1);
        clear(); set_wb(1, 5'd7, 1, 5'd7);
        cycle("ret7a");
        set_wb(1, 5'd7, 0, 0);
        cycle("ret7b");

        // Double retirement of r9 while another write to r9 issues.
        clear(); set_s1(0, 0, 0, 0, 1, 5'd9);
        cycle("w9a");
        cycle("w9b");
        set_wb(1, 5'd9, 1, 5'd9);
        cycle("w9_ret2");
        chk("w9_ret2.i1", 32'(obs_i1), 32'd1);
        clear();
        cycle("after9");
        chk("after9.busy9", 32'(obs_busy[9]), 32'd1);
        set_wb(1, 5'd9, 0, 0);
        cycle("ret9");
        clear();
        cycle("clean9");
        chk("clean9.busy9", 32'(obs_busy[9]), 32'd0);

        // Flush with writes outstanding.
        set_s1(0, 0, 0, 0, 1, 5'd4); set_s2(0, 0, 0, 0, 1, 5'd6);
        cycle("w4w6");
        clear(); set_s1(0, 0, 0, 0, 1, 5'd6);
        cycle("w6");
        clear(); flush = 1; set_s1(0, 0, 0, 0, 1, 5'd1); set_s2(0, 0, 0, 0, 1, 5'd2);
        set_wb(1, 5'd6, 0, 0);
        cycle("flush");
        chk("flush.i1", 32'(obs_i1), 32'd0);
        chk("flush.i2", 32'(obs_i2), 32'd0);
        chk("flush.busy", obs_busy, 32'h0000_0050);
        clear();
        cycle("post_flush");
        chk("post_flush.busy", obs_busy, 32'd0);
        set_wb(1, 5'd4, 0, 0);
        cycle("late_wb4");
        clear();
        cycle("after_wb4");
        chk("after_wb4.busy", obs_busy, 32'd0);

        // r0 is never tracked.
        set_s1(1, 5'd0, 1, 5'd0, 1, 5'd0); set_s2(1, 5'd0, 1, 5'd0, 1, 5'd0);
        cycle("r0");
        chk("r0.i1", 32'(obs_i1), 32'd1);
        chk("r0.i2", 32'(obs_i2), 32'd1);
        clear();
        cycle("after_r0");
        chk("after_r0.busy0", 32'(obs_busy[0]), 32'd0);

        // Reset mid-operation outranks flush and pending writes.
        set_s1(0, 0, 0, 0, 1, 5'd10);
        cycle("w10");
        set_s1(1, 5'd10, 0, 0, 0, 0);
        cycle("stall10");
        rst = 1; flush = 1;
        cycle("mid_rst");
        chk("mid_rst.i1", 32'(obs_i1), 32'd0);
        clear();
        cycle("after_rst");
        chk("after_rst.busy", obs_busy, 32'd0);
        chk("after_rst.stall", obs_stall, 32'd0);

        // Random traffic on a small register window to provoke hazards.
        for (int k = 0; k < 1500; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            pipe_ready = ($urandom_range(0, 7) != 0);
            valid_1    = ($urandom_range(0, 3) != 0);
            re1_1      = 1'($urandom_range(0, 1));
            raddr1_1   = 5'($urandom_range(0, 7));
            re2_1      = 1'($urandom_range(0, 1));
            raddr2_1   = 5'($urandom_range(0, 7));
            we_1       = 1'($urandom_range(0, 1));
            waddr_1    = 5'($urandom_range(0, 7));
            valid_2    = ($urandom_range(0, 3) != 0);
            re1_2      = 1'($urandom_range(0, 1));
            raddr1_2   = 5'($urandom_range(0, 7));
            re2_2      = 1'($urandom_range(0, 1));
            raddr2_2   = 5'($urandom_range(0, 7));
            we_2       = 1'($urandom_range(0, 1));
            waddr_2    = 5'($urandom_range(0, 7));
            wb_we_1    = ($urandom_range(0, 2) == 0);
            wb_waddr_1 = 5'($urandom_range(0, 7));
            wb_we_2    = ($urandom_range(0, 2) == 0);
            wb_waddr_2 = 5'($urandom_range(0, 7));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, giving the width of the per-register pending-write counter (maximum outstanding writes per register = 2^CNT_W-1).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  in  1  kills all in-flight instructions; clears the scoreboard.
REQ-005 SHALL have port pipe_ready  in  1  downstream execute stage can accept an issue group this cycle.
REQ-006 SHALL have, per slot s in {1,2}, ports valid_s in 1, re1_s in 1, raddr1_s in 5, re2_s in 1, raddr2_s in 5, we_s in 1, waddr_s in 5; these describe the decoded instruction offered for issue; slot 1 is older.
REQ-007 SHALL have ports wb_we_1 in 1, wb_waddr_1 in 5, wb_we_2 in 1, wb_waddr_2 in 5; these are the same-cycle register-file write ports (writeback retirement).
REQ-008 SHALL have ports issue_1 out 1, issue_2 out 1; each asserts when its slot fires this cycle.
REQ-009 SHALL have port stall_cnt out 32; it counts cycles with valid_1=1 and issue_1=0.
REQ-010 SHALL have port busy_vec out 32; bit r =1 iff pending[r]!=0.

Function
REQ-011 SHALL hold a CNT_W-bit counter pending[r] for r=1..31; pending[0] SHALL be constant 0, and writes to r0 SHALL be neither tracked nor counted.
REQ-012 SHALL define avail(r) = (r==0) or (pending[r] - number of wb ports writing r this cycle == 0); a register retiring this cycle is available because the register file bypasses same-cycle write data to reads.
REQ-013 SHALL assert issue_1 combinationally iff valid_1 & pipe_ready & !flush & (!re1_1 | avail(raddr1_1)) & (!re2_1 | avail(raddr2_1)) & (!we_1 | waddr_1==0 | pending[waddr_1] < max).
REQ-014 SHALL assert issue_2 only when issue_1 is asserted (in-order), and iff the slot-1 conditions hold for slot 2 and there is no RAW hazard on slot 1: not (we_1 & waddr_1!=0 & ((re1_2 & raddr1_2==waddr_1) | (re2_2 & raddr2_2==waddr_1))).
REQ-015 SHALL, when both slots write the same nonzero register, require pending[r] <= max-2 for issue_2; otherwise only slot 1 issues.
REQ-016 SHALL, on each posedge without rst/flush, update pending[r] := pending[r] + (issued writes to r) - (wb writes to r); issue and retire of the same r in one cycle net out; two wb ports writing the same r SHALL decrement by 2.
REQ-017 SHALL ignore a wb write to r with pending[r]==0 (no underflow; counter stays 0).
REQ-018 SHALL make scoreboard updates visible to issue decisions the cycle after the update edge (1-cycle latency); busy_vec SHALL reflect registered state.
REQ-019 SHALL, on flush, clear all pending[] at the next edge, force issue_1=issue_2=0 in the flush cycle, and ignore wb writes in that cycle.
REQ-020 SHALL increment stall_cnt by 1 per qualifying cycle (REQ-009), wrapping 0xFFFFFFFF->0; flush cycles SHALL NOT count.
REQ-021 SHALL NOT use pc ordering: slot 1 is always the older instruction.

Reset
REQ-022 SHALL, with rst=1 at a posedge, clear all pending[] and stall_cnt to 0; busy_vec SHALL be 0 from the following cycle.
REQ-023 SHALL force issue_1=issue_2=0 while rst=1; rst SHALL take priority over flush and all updates, including reset asserted mid-operation with writes outstanding.

Verification
REQ-024 SHALL pass: slot1 we r5 issues; next cycle slot1 reads r5, no wb -> issue_1=0, stall_cnt increments; wb_we_1 r5 that cycle -> issue_1=1 (bypass), pending[5] ends 0.
REQ-025 SHALL pass: slot1 writes r3, slot2 reads r3, both valid, pipe_ready=1 -> issue_1=1, issue_2=0; pending[3]=1 next cycle.
REQ-026 SHALL pass: both slots write r7 with pending[7]=2 (CNT_W=2) -> issue_1=1, issue_2=0; pending[7]=3; a further write to r7 stalls until a wb.
REQ-027 SHALL pass: both wb ports retire r9 with pending[9]=2 while slot1 issues a write to r9 -> pending[9]=1.
REQ-028 SHALL pass: pending[4]=1, pending[6]=2, flush=1 -> issues 0 that cycle; busy_vec=0 next cycle; a wb r4 arriving later leaves pending[4]=0.
REQ-029 SHALL pass: slot with we=1, waddr=0 and reads of r0 -> always issues; busy_vec[0] stays 0.
